// File: rtl/tdm_slot_timer_if.sv
// Frame-pulse, slot-select and timing-output bundle of the TDM slot timer.
// The master side is the converter front end; the slave side is the timer.
interface tdm_slot_timer_if #(
  parameter int SLOT_W = 5
);
  logic              f0;
  logic              select;
  logic [SLOT_W-1:0] tx_slot;
  logic [SLOT_W-1:0] rx_slot;
  logic              clk_en_tx;
  logic              clk_en_rx;
  logic              clk_tx;
  logic              clk_rx;
  logic              locked;
  logic              sync_err;

  modport master (
    output f0, select, tx_slot, rx_slot,
    input  clk_en_tx, clk_en_rx, clk_tx, clk_rx, locked, sync_err
  );

  modport slave (
    input  f0, select, tx_slot, rx_slot,
    output clk_en_tx, clk_en_rx, clk_tx, clk_rx, locked, sync_err
  );
endinterface

// File: rtl/tdm_slot_timer.sv
// ST-BUS style TDM slot timer: follows the f0 frame pulse, qualifies frame lock
// and decodes TX/RX slot enables and bit strobes from the frame position.
module tdm_slot_timer #(
  parameter int CHANNELS    = 32,
  parameter int BITS        = 8,
  parameter int CLK_PER_BIT = 2,
  parameter int LOCK_FRAMES = 2,
  parameter int MISS_MAX    = 2,
  parameter int RX_PHASE0   = 1,
  parameter int RX_PHASE1   = 0
) (
  input  logic            c4,
  input  logic            rst,
  tdm_slot_timer_if.slave bus
);
  localparam int FRAME_LEN = CHANNELS * BITS * CLK_PER_BIT;
  localparam int SLOT_LEN  = BITS * CLK_PER_BIT;
  localparam int SLOT_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam int PH_W      = $clog2(CLK_PER_BIT);
  localparam int GOOD_W    = $clog2(LOCK_FRAMES + 1);
  localparam int MISS_W    = $clog2(MISS_MAX + 1);

  typedef enum logic {UNLOCKED, LOCKED} lock_e;

  lock_e             state_q, state_d;
  logic              f0_q;
  logic              first_q, first_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SLOT_W-1:0] tx_sel_q, tx_sel_d, rx_sel_q, rx_sel_d, slot;
  logic [PH_W-1:0]   phase, rx_phase;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              fedge, wrap, lock_d, sync_err_d, tx_hit, rx_hit;
  logic              en_tx_q, en_rx_q, clk_tx_q, clk_rx_q, sync_err_q;

  assign fedge    = !bus.f0 && f0_q;
  assign wrap     = (cnt_q == CNT_W'(FRAME_LEN - 1));
  assign cnt_d    = (fedge || wrap) ? '0 : cnt_q + 1'b1;
  assign slot     = SLOT_W'(cnt_q / CNT_W'(SLOT_LEN));
  assign phase    = PH_W'(cnt_q % CNT_W'(CLK_PER_BIT));
  assign rx_phase = bus.select ? PH_W'(RX_PHASE1) : PH_W'(RX_PHASE0);

  // Selections are taken at position 0 so a whole frame decodes one request.
  assign tx_sel_d = (cnt_q == '0) ? bus.tx_slot : tx_sel_q;
  assign rx_sel_d = (cnt_q == '0) ? bus.rx_slot : rx_sel_q;
  assign tx_hit   = (slot == tx_sel_d);
  assign rx_hit   = (slot == rx_sel_d);
  assign lock_d   = (state_d == LOCKED);

  always_comb begin
    state_d    = state_q;
    good_d     = good_q;
    miss_d     = miss_q;
    first_d    = first_q;
    sync_err_d = 1'b0;
    if (fedge) begin
      first_d = 1'b0;
      miss_d  = '0;
      // The first pulse after reset has no reference position, so trust it.
      if (wrap || first_q) begin
        if (int'(good_q) < LOCK_FRAMES) good_d = good_q + 1'b1;
        if (int'(good_q) + 1 >= LOCK_FRAMES) state_d = LOCKED;
      end else begin
        sync_err_d = 1'b1;
        good_d     = '0;
        state_d    = UNLOCKED;
      end
    end else if (wrap) begin
      if (int'(miss_q) < MISS_MAX) miss_d = miss_q + 1'b1;
      if (int'(miss_q) + 1 >= MISS_MAX) begin
        state_d = UNLOCKED;
        good_d  = '0;
      end
    end
  end

  always_ff @(posedge c4) begin
    if (rst) begin
      f0_q       <= 1'b1;
      cnt_q      <= '0;
      tx_sel_q   <= '0;
      rx_sel_q   <= '0;
      good_q     <= '0;
      miss_q     <= '0;
      first_q    <= 1'b1;
      state_q    <= UNLOCKED;
      en_tx_q    <= 1'b0;
      en_rx_q    <= 1'b0;
      clk_tx_q   <= 1'b0;
      clk_rx_q   <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      f0_q       <= bus.f0;
      cnt_q      <= cnt_d;
      tx_sel_q   <= tx_sel_d;
      rx_sel_q   <= rx_sel_d;
      good_q     <= good_d;
      miss_q     <= miss_d;
      first_q    <= first_d;
      state_q    <= state_d;
      en_tx_q    <= lock_d && tx_hit;
      en_rx_q    <= lock_d && rx_hit;
      clk_tx_q   <= lock_d && tx_hit && (phase == '0);
      clk_rx_q   <= lock_d && rx_hit && (phase == rx_phase);
      sync_err_q <= sync_err_d;
    end
  end

  assign bus.clk_en_tx = en_tx_q;
  assign bus.clk_en_rx = en_rx_q;
  assign bus.clk_tx    = clk_tx_q;
  assign bus.clk_rx    = clk_rx_q;
  assign bus.locked    = (state_q == LOCKED);
  assign bus.sync_err  = sync_err_q;
endmodule

// File: doc/tdm_slot_timer.md
# tdm_slot_timer

Parametrised ST-BUS style TDM timing generator that takes over and generalises the single-channel frame converter. It runs on the `c4` bit-clock domain and tracks the active-low frame pulse `f0`. It produces per-slot transmit and receive enables plus bit strobes for independently selectable TX and RX timeslots. It also adds frame-lock qualification and sync-error detection, which the converter front end uses to gate codec traffic.

## Interface

- `CHANNELS`, 32: timeslots per frame.
- `BITS`, 8: bits per timeslot.
- `CLK_PER_BIT`, 2: `c4` cycles per bit, must be ≥ 2.
- `LOCK_FRAMES`, 2: consecutive correctly spaced frame pulses required to declare lock.
- `MISS_MAX`, 2: consecutive missing frame pulses that drop lock.
- `RX_PHASE0`, 1: RX sample phase used when `select`=0, in range 0..CLK_PER_BIT-1.
- `RX_PHASE1`, 0: RX sample phase used when `select`=1, in range 0..CLK_PER_BIT-1.
- Derived: `FRAME_LEN` = CHANNELS·BITS·CLK_PER_BIT. `SLOT_W` = clog2(CHANNELS).
- `c4`, in, 1: the only clock, rising edge.
- `rst`, in, 1: synchronous reset, active-high.
- `f0`, in, 1: frame pulse, active low, synchronous to `c4`.
- `select`, in, 1: RX sample-phase mode.
- `tx_slot`, in, SLOT_W: requested TX timeslot.
- `rx_slot`, in, SLOT_W: requested RX timeslot.
- `clk_en_tx`, out, 1: high for the whole selected TX slot.
- `clk_en_rx`, out, 1: high for the whole selected RX slot.
- `clk_tx`, out, 1: one-cycle TX shift strobe, once per bit.
- `clk_rx`, out, 1: one-cycle RX sample strobe, once per bit.
- `locked`, out, 1: frame lock status.
- `sync_err`, out, 1: one-cycle pulse on a misplaced frame pulse.

## Operation

- **Frame edge:** `f0` is registered into `f0_q`. A frame edge is any cycle where `f0`=0 and `f0_q`=1.
- **Position counter:** `cnt` spans 0..FRAME_LEN-1.
  - On a frame edge, `cnt` is loaded with 0 on the next cycle.
  - Otherwise `cnt` increments and wraps from FRAME_LEN-1 to 0, so it free-runs when `f0` is absent.
- **Decode from `cnt`:**
  - slot = cnt / (BITS·CLK_PER_BIT)
  - bit = (cnt / CLK_PER_BIT) mod BITS
  - phase = cnt mod CLK_PER_BIT
- **Slot latching:** `tx_slot` and `rx_slot` are latched into `tx_sel` and `rx_sel` only when `cnt`=0. Changes made mid-frame take effect in the next frame. A selection ≥ CHANNELS never matches, so its enables and strobes stay 0.
- **Lock state machine:** states UNLOCKED and LOCKED. A `good` counter saturates at LOCK_FRAMES and a `miss` counter saturates at MISS_MAX.
  - Edge while `cnt`=FRAME_LEN-1: `good`++, `miss`=0. UNLOCKED→LOCKED when `good` reaches LOCK_FRAMES.
  - Edge at any other `cnt`: `sync_err`=1 for one cycle, `good`=0, state→UNLOCKED. The counter still realigns to 0.
  - `cnt` wraps with no edge in that cycle: `miss`++. Reaching MISS_MAX → UNLOCKED and `good`=0.
  - In UNLOCKED, an edge while `cnt`=FRAME_LEN-1 counts as good. The first edge after reset also counts as good, even though `cnt` has not reached FRAME_LEN-1.
- **Outputs:** all are gated by `locked`.
  - `clk_en_tx` = (slot == tx_sel).
  - `clk_tx` = `clk_en_tx` condition AND phase == 0.
  - `clk_en_rx` = (slot == rx_sel).
  - `clk_rx` = `clk_en_rx` condition AND phase == (`select` ? RX_PHASE1 : RX_PHASE0).
- **Shared slot:** `tx_sel` == `rx_sel` is legal. Both paths then operate in the same slot.

## Timing

- **Reset:** `cnt`=0, `f0_q`=1, `tx_sel`=`rx_sel`=0, `good`=`miss`=0, state UNLOCKED. All outputs are 0 in the cycle after `rst` is sampled high. Reset mid-frame discards lock immediately.
- **Output registration:** all outputs are registered. If `cnt`=k in cycle t, the outputs reflect k in cycle t+1.
- **Per-frame shape:** each enable is high for exactly BITS·CLK_PER_BIT consecutive cycles. Each strobe pulses exactly BITS times per frame.
- **Lock timing:** `locked` rises in the cycle after the qualifying edge. It falls in the cycle after the error edge or the MISS_MAX-th miss.
- **Simultaneous events:**
  - An edge exactly at the wrap position is good, not a miss.
  - `rst` overrides everything, including an edge in the same cycle.
  - `select` is not latched, so a change takes effect on the next strobe decision.

## Test plan

1. **Acquire lock:** `f0` low for 1 cycle every 512 cycles, with `tx_slot`=3 and `rx_slot`=3 → `locked` rises after the 2nd pulse. Then `clk_en_tx` is high for `cnt` 48..63, delayed 1 cycle, and `clk_tx` pulses 8 times at even `cnt`.
2. **RX phase select:** locked, `rx_slot`=0, `select`=0 → `clk_rx` at `cnt` 1,3,…,15. With `select`=1 → `clk_rx` at `cnt` 0,2,…,14.
3. **Misplaced pulse:** locked, then an extra `f0` pulse at `cnt`=200 → `sync_err` pulses once and `locked` drops. `cnt` restarts at 0, and lock returns after 2 more correctly spaced pulses.
4. **Missing pulses:** locked, then `f0` held high → `locked` stays 1 through the first wrap and drops at the second wrap. `cnt` keeps free-running.
5. **Slot change mid-frame:** `tx_slot` changed 3→10 at `cnt`=100 → the current frame still enables slot 3. The next frame enables `cnt` 160..175, and an out-of-range request produces no enable.
6. **Reset mid-operation:** `rst` asserted at `cnt`=300 while locked → all outputs are 0 on the next cycle, and relocking requires fresh pulses.
